// File: rtl/mul_error_scanner.sv
// rtl/mul_error_scanner.sv - exhaustive operand sweep and error accumulation for an attached multiplier
module mul_error_scanner #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     mul_in1,
  output logic [WIDTH-1:0]     mul_in2,
  input  logic [2*WIDTH:0]     mul_out,
  input  logic                 mul_overflow,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [4*WIDTH:0]     sum_ed,
  output logic [2*WIDTH:0]     max_ed,
  output logic [2*WIDTH:0]     ovf_count,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_in1,
  output logic [WIDTH-1:0]     first_err_in2
);

  localparam int PW = 2*WIDTH + 1;
  localparam int SW = 4*WIDTH + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     settle_cnt;
  logic              accept;
  logic              settle_last;
  logic              last_pair;
  logic [2*WIDTH-1:0] prod;
  logic [PW-1:0]     exact;
  logic [PW-1:0]     ed;

  assign accept      = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign settle_last = (settle_cnt == CW'(SETTLE - 1));
  assign last_pair   = (&mul_in1) && (&mul_in2);

  // mul_out is allowed to exceed any legal product, so the distance is
  // taken in the full PW-bit unsigned domain rather than the product width.
  always_comb begin
    prod  = (2*WIDTH)'(mul_in1) * (2*WIDTH)'(mul_in2);
    exact = {1'b0, prod};
    ed    = (mul_out >= exact) ? (mul_out - exact) : (exact - mul_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_WAIT;
      S_WAIT:   if (settle_last) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_pair ? S_DONE : S_WAIT;
      S_DONE:   if (start) state_nxt = S_WAIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_WAIT, S_SAMPLE: busy = 1'b1;
      S_DONE:           done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_in1         <= '0;
      mul_in2         <= '0;
      settle_cnt      <= '0;
      err_count       <= '0;
      sum_ed          <= '0;
      max_ed          <= '0;
      ovf_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_in1   <= '0;
      first_err_in2   <= '0;
    end else if (accept) begin
      mul_in1         <= '0;
      mul_in2         <= '0;
      settle_cnt      <= '0;
      err_count       <= '0;
      sum_ed          <= '0;
      max_ed          <= '0;
      ovf_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_in1   <= '0;
      first_err_in2   <= '0;
    end else if (state == S_WAIT) begin
      settle_cnt <= settle_cnt + CW'(1);
    end else if (state == S_SAMPLE) begin
      if (ed != '0) begin
        err_count <= err_count + PW'(1);
        sum_ed    <= sum_ed + SW'(ed);
        if (ed > max_ed) begin
          max_ed <= ed;
        end
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_in1   <= mul_in1;
          first_err_in2   <= mul_in2;
        end
      end
      if (mul_overflow) begin
        ovf_count <= ovf_count + PW'(1);
      end
      // Operands hold at all ones once the final pair is sampled.
      if (!last_pair) begin
        settle_cnt <= '0;
        if (&mul_in1) begin
          mul_in1 <= '0;
          mul_in2 <= mul_in2 + WIDTH'(1);
        end else begin
          mul_in1 <= mul_in1 + WIDTH'(1);
        end
      end
    end
  end

endmodule
